// File: rtl/gray_step_checker_pkg.sv
// Shared definitions for the Gray-stream step checker.
// Holds the FSM state encoding and the default stream width.
package gray_pkg;

  localparam logic [1:0] SYNC_ENC    = 2'd0;
  localparam logic [1:0] ACQUIRE_ENC = 2'd1;
  localparam logic [1:0] LOCKED_ENC  = 2'd2;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_SYNC    = SYNC_ENC,
    ST_ACQUIRE = ACQUIRE_ENC,
    ST_LOCKED  = LOCKED_ENC
  } state_t;

endpackage

// File: rtl/gray_step_checker_gray2bin.sv
// Combinational Gray-to-binary decoder, WIDTH-parameterised.
// Each binary bit is the XOR of its Gray bit and every Gray bit above it.
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_step_checker.sv
// Checks a registered Gray-code counter stream for single +1 steps and stalls,
// reporting decoded value, step/error strobes, lock status and an error count.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_SYNC    | one cycle after reset: load bin_out, no classification
// ACQUIRE    | counting consecutive valid steps towards lock; errors silent
// LOCKED     | stream trusted; any stall or jump is reported and counted
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH      = GRAY_WIDTH,
  parameter int HOLD_MAX   = 2,
  parameter int LOCK_STEPS = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_pulse,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int HC_W = $clog2(HOLD_MAX) + 1;
  localparam int SC_W = $clog2(LOCK_STEPS) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(LOCK_STEPS - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_g_q;
  logic [WIDTH-1:0]     r_bin;
  logic [HC_W-1:0]      r_hold_cnt;
  logic [SC_W-1:0]      r_step_cnt;
  logic                 r_step_pulse;
  logic                 r_locked;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0]     w_d;
  logic [WIDTH-1:0]     w_bin_inc;
  logic                 w_is_step;
  logic                 w_is_hold;
  logic                 w_stall;
  logic                 w_jump;
  logic                 w_bad;

  state_t               w_state_nxt;
  logic [HC_W-1:0]      w_hold_nxt;
  logic [SC_W-1:0]      w_step_nxt;
  logic                 w_step_pulse_nxt;
  logic                 w_err_pulse_nxt;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (r_g_q),
    .o_bin  (w_d)
  );

  // Classification of the freshly decoded sample against the previous one.
  always_comb begin
    w_bin_inc = r_bin + WIDTH'(1);
    w_is_step = (w_d == w_bin_inc);
    w_is_hold = (w_d == r_bin);
    w_stall   = w_is_hold && (r_hold_cnt == HOLD_LAST);
    w_jump    = !w_is_step && !w_is_hold;
    w_bad     = w_stall || w_jump;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = '0;
    w_step_nxt       = r_step_cnt;
    w_step_pulse_nxt = 1'b0;
    w_err_pulse_nxt  = 1'b0;
    w_err_cnt_nxt    = r_err_cnt;

    if (r_state != ST_SYNC && w_is_hold && !w_stall) begin
      w_hold_nxt = r_hold_cnt + HC_W'(1);
    end

    case (r_state)
      ST_SYNC: begin
        w_state_nxt = ST_ACQUIRE;
        w_step_nxt  = '0;
      end
      ST_ACQUIRE: begin
        if (w_is_step) begin
          w_step_pulse_nxt = 1'b1;
          if (r_step_cnt == STEP_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_step_nxt  = '0;
          end else begin
            w_step_nxt = r_step_cnt + SC_W'(1);
          end
        end else if (w_bad) begin
          w_step_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (w_is_step) begin
          w_step_pulse_nxt = 1'b1;
        end else if (w_bad) begin
          w_err_pulse_nxt = 1'b1;
          w_step_nxt      = '0;
          w_state_nxt     = ST_ACQUIRE;
          if (r_err_cnt != '1) begin
            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_SYNC;
        w_step_nxt  = '0;
      end
    endcase

    // Clear beats a coincident increment; the error strobe is unaffected.
    if (clr_err) begin
      w_err_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SYNC;
      r_g_q        <= '0;
      r_bin        <= '0;
      r_hold_cnt   <= '0;
      r_step_cnt   <= '0;
      r_step_pulse <= 1'b0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_g_q        <= gray_in;
      r_bin        <= w_d;
      r_hold_cnt   <= w_hold_nxt;
      r_step_cnt   <= w_step_nxt;
      r_step_pulse <= w_step_pulse_nxt;
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_err_pulse  <= w_err_pulse_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign bin_out    = r_bin;
  assign step_pulse = r_step_pulse;
  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_gray_step_checker.sv
// Directed bench for gray_step_checker: lock-up, wrap, jump, stall, error
// counter saturation/clear and asynchronous reset, on 8-bit and 2-bit counters.
module tb_gray_step_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] gray_in = 4'b0000;
  logic       clr_err = 1'b0;

  logic [3:0] bin_out,  bin_out2;
  logic       step_pulse, step_pulse2;
  logic       locked, locked2;
  logic       err_pulse, err_pulse2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  logic [3:0] GRAY [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  gray_step_checker #(
    .WIDTH(4), .HOLD_MAX(2), .LOCK_STEPS(2), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .step_pulse(step_pulse), .locked(locked),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  gray_step_checker #(
    .WIDTH(4), .HOLD_MAX(2), .LOCK_STEPS(2), .ERR_CNT_W(2)
  ) dut_w2 (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out2), .step_pulse(step_pulse2), .locked(locked2),
    .err_pulse(err_pulse2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_bin, input logic e_sp,
                         input logic e_lk, input logic e_ep, input logic [7:0] e_cnt,
                         input logic [1:0] e_cnt2);
    chk($sformatf("%s.bin", tag),    32'(bin_out),     32'(e_bin));
    chk($sformatf("%s.step", tag),   32'(step_pulse),  32'(e_sp));
    chk($sformatf("%s.locked", tag), 32'(locked),      32'(e_lk));
    chk($sformatf("%s.err", tag),    32'(err_pulse),   32'(e_ep));
    chk($sformatf("%s.cnt", tag),    32'(err_cnt),     32'(e_cnt));
    chk($sformatf("%s.bin2", tag),   32'(bin_out2),    32'(e_bin));
    chk($sformatf("%s.step2", tag),  32'(step_pulse2), 32'(e_sp));
    chk($sformatf("%s.locked2", tag),32'(locked2),     32'(e_lk));
    chk($sformatf("%s.err2", tag),   32'(err_pulse2),  32'(e_ep));
    chk($sformatf("%s.cnt2", tag),   32'(err_cnt2),    32'(e_cnt2));
  endtask

  task automatic edge_in(input logic [3:0] g, input logic clr);
    gray_in = g;
    clr_err = clr;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  // From reset: SYNC loads 0, the stale reset sample plus the first held 0
  // count as a stall in ACQUIRE, then two steps (1, 2) lock.
  task automatic lock_from_reset(input string tag);
    edge_in(GRAY[0], 1'b0); chk_all({tag, "_sync"},  4'd0, 0, 0, 0, 8'd0, 2'd0);
    edge_in(GRAY[0], 1'b0); chk_all({tag, "_hold0"}, 4'd0, 0, 0, 0, 8'd0, 2'd0);
    edge_in(GRAY[1], 1'b0); chk_all({tag, "_stall0"},4'd0, 0, 0, 0, 8'd0, 2'd0);
    edge_in(GRAY[1], 1'b0); chk_all({tag, "_step1"}, 4'd1, 1, 0, 0, 8'd0, 2'd0);
    edge_in(GRAY[2], 1'b0); chk_all({tag, "_hold1"}, 4'd1, 0, 0, 0, 8'd0, 2'd0);
    edge_in(GRAY[2], 1'b0); chk_all({tag, "_lock"},  4'd2, 1, 1, 0, 8'd0, 2'd0);
  endtask

  // From LOCKED at b: jump to b+3 (error), then relock via b+4 and b+5.
  task automatic jump_relock(input logic [3:0] b, input logic clr,
                             input logic [7:0] p8, input logic [1:0] p2,
                             input logic [7:0] e8, input logic [1:0] e2);
    logic [3:0] j, a, c;
    j = b + 4'd3;
    a = b + 4'd4;
    c = b + 4'd5;
    edge_in(GRAY[j], 1'b0); chk_all($sformatf("jr%0d_pre", b),  b, 0, 1, 0, p8, p2);
    edge_in(GRAY[j], clr);  chk_all($sformatf("jr%0d_jump", b), j, 0, 0, 1, e8, e2);
    edge_in(GRAY[a], 1'b0); chk_all($sformatf("jr%0d_h1", b),   j, 0, 0, 0, e8, e2);
    edge_in(GRAY[a], 1'b0); chk_all($sformatf("jr%0d_s1", b),   a, 1, 0, 0, e8, e2);
    edge_in(GRAY[c], 1'b0); chk_all($sformatf("jr%0d_h2", b),   a, 0, 0, 0, e8, e2);
    edge_in(GRAY[c], 1'b0); chk_all($sformatf("jr%0d_lock", b), c, 1, 1, 0, e8, e2);
  endtask

  initial begin
    logic [3:0] vv, pv;

    #1 rst_n = 1'b0;
    #1 chk_all("reset", 4'd0, 0, 0, 0, 8'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1 chk_all("reset_clk", 4'd0, 0, 0, 0, 8'd0, 2'd0);
    rst_n = 1'b1;

    lock_from_reset("init");

    // Upstream-style run 3..15 and wrap 15 -> 0 while locked.
    for (int v = 3; v <= 16; v++) begin
      vv = 4'(v);
      pv = vv - 4'd1;
      edge_in(GRAY[vv], 1'b0); chk_all($sformatf("run%0d_h", v), pv, 0, 1, 0, 8'd0, 2'd0);
      edge_in(GRAY[vv], 1'b0); chk_all($sformatf("run%0d_s", v), vv, 1, 1, 0, 8'd0, 2'd0);
    end
    for (int v = 1; v <= 2; v++) begin
      vv = 4'(v);
      pv = vv - 4'd1;
      edge_in(GRAY[vv], 1'b0); chk_all($sformatf("post%0d_h", v), pv, 0, 1, 0, 8'd0, 2'd0);
      edge_in(GRAY[vv], 1'b0); chk_all($sformatf("post%0d_s", v), vv, 1, 1, 0, 8'd0, 2'd0);
    end

    // Jump 2 -> 4 while locked, then relock on 5, 6.
    edge_in(GRAY[4], 1'b0); chk_all("jmp_pre",   4'd2, 0, 1, 0, 8'd0, 2'd0);
    edge_in(GRAY[4], 1'b0); chk_all("jmp",       4'd4, 0, 0, 1, 8'd1, 2'd1);
    edge_in(GRAY[5], 1'b0); chk_all("jmp_after", 4'd4, 0, 0, 0, 8'd1, 2'd1);
    edge_in(GRAY[5], 1'b0); chk_all("jmp_s1",    4'd5, 1, 0, 0, 8'd1, 2'd1);
    edge_in(GRAY[6], 1'b0); chk_all("jmp_h2",    4'd5, 0, 0, 0, 8'd1, 2'd1);
    edge_in(GRAY[6], 1'b0); chk_all("jmp_relock",4'd6, 1, 1, 0, 8'd1, 2'd1);

    // Stall: Gray 0101 present for a third sample.
    edge_in(GRAY[6], 1'b0); chk_all("stall_h",   4'd6, 0, 1, 0, 8'd1, 2'd1);
    edge_in(GRAY[6], 1'b0); chk_all("stall",     4'd6, 0, 0, 1, 8'd2, 2'd2);
    edge_in(GRAY[7], 1'b0); chk_all("stall_h1",  4'd6, 0, 0, 0, 8'd2, 2'd2);
    edge_in(GRAY[7], 1'b0); chk_all("stall_s1",  4'd7, 1, 0, 0, 8'd2, 2'd2);
    edge_in(GRAY[8], 1'b0); chk_all("stall_h2",  4'd7, 0, 0, 0, 8'd2, 2'd2);
    edge_in(GRAY[8], 1'b0); chk_all("stall_lock",4'd8, 1, 1, 0, 8'd2, 2'd2);

    // Clear with no error pending.
    edge_in(GRAY[9], 1'b1); chk_all("clr_idle",  4'd8, 0, 1, 0, 8'd0, 2'd0);
    edge_in(GRAY[9], 1'b0); chk_all("clr_step",  4'd9, 1, 1, 0, 8'd0, 2'd0);

    // Saturation of the 2-bit counter, then clear coincident with an error.
    jump_relock(4'd9,  1'b0, 8'd0, 2'd0, 8'd1, 2'd1);
    jump_relock(4'd14, 1'b0, 8'd1, 2'd1, 8'd2, 2'd2);
    jump_relock(4'd3,  1'b0, 8'd2, 2'd2, 8'd3, 2'd3);
    jump_relock(4'd8,  1'b0, 8'd3, 2'd3, 8'd4, 2'd3);
    jump_relock(4'd13, 1'b1, 8'd4, 2'd3, 8'd0, 2'd0);
    jump_relock(4'd2,  1'b0, 8'd0, 2'd0, 8'd1, 2'd1);

    // Asynchronous reset between edges while locked.
    #3 rst_n = 1'b0;
    #1 chk_all("rst_async", 4'd0, 0, 0, 0, 8'd0, 2'd0);
    gray_in = GRAY[0];
    @(posedge clk);
    #1 chk_all("rst_held", 4'd0, 0, 0, 0, 8'd0, 2'd0);
    rst_n = 1'b1;
    lock_from_reset("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
